// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the write-back data cache.
package dcache_pkg;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned AddrWidth   = 10;
  localparam int unsigned IndexWidth  = 5;
  localparam int unsigned OffsetWidth = 3;
  localparam int unsigned TagWidth    = AddrWidth - IndexWidth - OffsetWidth;
  localparam int unsigned LineWords   = 1 << OffsetWidth;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StRefill
  } state_e;

  function automatic logic [TagWidth-1:0] tag_of(input logic [AddrWidth-1:0] a);
    return a[AddrWidth-1 -: TagWidth];
  endfunction

  function automatic logic [IndexWidth-1:0] index_of(input logic [AddrWidth-1:0] a);
    return a[OffsetWidth +: IndexWidth];
  endfunction

  function automatic logic [OffsetWidth-1:0] offset_of(input logic [AddrWidth-1:0] a);
    return a[OffsetWidth-1:0];
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Cache line word store: asynchronous read, single synchronous write port.
module dcache_data_array #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH  = 5,
  parameter int unsigned OFFSET_WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic [INDEX_WIDTH-1:0]  rd_index_i,
  input  logic [OFFSET_WIDTH-1:0] rd_offset_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic [INDEX_WIDTH-1:0]  wr_index_i,
  input  logic [OFFSET_WIDTH-1:0] wr_offset_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i
);

  localparam int unsigned Words = 1 << (INDEX_WIDTH + OFFSET_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/dcache_wb_responder.sv
// Direct-mapped write-back, write-allocate data cache answering CPU MEM-stage requests;
// misses write back a dirty victim then refill the line from a 1-cycle-latency BRAM.
module dcache_wb_responder
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned INDEX_WIDTH  = 5,
  parameter int unsigned OFFSET_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  we_i,
  input  logic                  mem_en_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned TagW      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned Lines     = 1 << INDEX_WIDTH;
  localparam int unsigned Words     = 1 << OFFSET_WIDTH;
  localparam int unsigned CntW      = OFFSET_WIDTH + 1;
  localparam logic [CntW-1:0] CntWbLast = CntW'(Words - 1);
  localparam logic [CntW-1:0] CntRfLast = CntW'(Words);

  logic [TagW-1:0]         req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [TagW-1:0]         miss_tag_q;
  logic [TagW-1:0]         victim_tag_q;
  logic [INDEX_WIDTH-1:0]  miss_index_q;
  logic [Lines-1:0]        valid_q;
  logic [Lines-1:0]        dirty_q;
  logic [TagW-1:0]         tag_q [Lines];
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_we_q;

  logic                    hit;
  logic [OFFSET_WIDTH-1:0] cnt_off;
  logic [INDEX_WIDTH-1:0]  rd_index;
  logic [OFFSET_WIDTH-1:0] rd_offset;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    arr_we;
  logic [INDEX_WIDTH-1:0]  wr_index;
  logic [OFFSET_WIDTH-1:0] wr_offset;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    refill_done;

  assign req_tag    = addr_i[ADDR_WIDTH-1 -: TagW];
  assign req_index  = addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_offset = addr_i[OFFSET_WIDTH-1:0];
  assign cnt_off    = cnt_q[OFFSET_WIDTH-1:0];

  assign hit = mem_en_i && (state_q == StIdle) && valid_q[req_index] &&
               (tag_q[req_index] == req_tag);
  assign refill_done = (state_q == StRefill) && (cnt_q == CntRfLast);

  // The single read port serves the CPU in IDLE and the victim drain in WRITEBACK.
  always_comb begin
    rd_index  = req_index;
    rd_offset = req_offset;
    if (state_q == StWriteback) begin
      rd_index  = miss_index_q;
      rd_offset = cnt_off;
    end
  end

  // Refill data arrives one cycle after its address, hence word cnt-1.
  always_comb begin
    arr_we    = 1'b0;
    wr_index  = req_index;
    wr_offset = req_offset;
    wr_data   = din_i;
    if ((state_q == StRefill) && (cnt_q != '0)) begin
      arr_we    = 1'b1;
      wr_index  = miss_index_q;
      wr_offset = OFFSET_WIDTH'(cnt_q - CntW'(1));
      wr_data   = mem_rdata_i;
    end else if (hit && we_i) begin
      arr_we = 1'b1;
    end
  end

  dcache_data_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_data_array (
    .clk_i      (clk_i),
    .rd_index_i (rd_index),
    .rd_offset_i(rd_offset),
    .rd_data_o  (rd_data),
    .wr_en_i    (arr_we),
    .wr_index_i (wr_index),
    .wr_offset_i(wr_offset),
    .wr_data_i  (wr_data)
  );

  always_comb begin
    mem_addr_o = mem_addr_q;
    unique case (state_q)
      StWriteback: mem_addr_o = {victim_tag_q, miss_index_q, cnt_off};
      StRefill: begin
        if (cnt_q != CntRfLast) begin
          mem_addr_o = {miss_tag_q, miss_index_q, cnt_off};
        end
      end
      default: mem_addr_o = mem_addr_q;
    endcase
  end

  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_we_q ? rd_data : '0;
  assign hit_o       = hit;
  assign dout_o      = hit ? rd_data : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      miss_tag_q   <= '0;
      victim_tag_q <= '0;
      miss_index_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_o;
      unique case (state_q)
        StIdle: begin
          if (hit && we_i) begin
            dirty_q[req_index] <= 1'b1;
          end else if (mem_en_i && !hit) begin
            miss_tag_q   <= req_tag;
            miss_index_q <= req_index;
            victim_tag_q <= tag_q[req_index];
            cnt_q        <= '0;
            if (valid_q[req_index] && dirty_q[req_index]) begin
              state_q  <= StWriteback;
              mem_we_q <= 1'b1;
            end else begin
              state_q <= StRefill;
            end
          end
        end
        StWriteback: begin
          if (cnt_q == CntWbLast) begin
            dirty_q[miss_index_q] <= 1'b0;
            cnt_q                 <= '0;
            mem_we_q              <= 1'b0;
            state_q               <= StRefill;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRefill: begin
          if (cnt_q == CntRfLast) begin
            valid_q[miss_index_q] <= 1'b1;
            dirty_q[miss_index_q] <= 1'b0;
            cnt_q                 <= '0;
            state_q               <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag store has no reset; valid bits alone qualify it.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      tag_q[miss_index_q] <= miss_tag_q;
    end
  end

endmodule
